vga_block_axil_regs: RTL and testbench
======================================

// Module: vga_block_axil_regs
// PURPOSE
//  AXI4-Lite slave register file for vga_block: the responder to the AXI4-Lite master on S00_AXI.
//  Holds 4 x 32-bit RW registers (CTRL, POS_X, POS_Y, COLOR) for software access.
//  Presents frame-synchronous shadow copies to the VGA pixel logic; shadows update only at frame start.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  4   byte address width; addr[3:2] selects the register, addr[1:0] is ignored.
// PORTS
//  S_AXI_ACLK     in   1   single clock for the whole block.
//  S_AXI_ARESETN  in   1   asynchronous, active-low reset.
//  S_AXI_AWADDR   in   4   write address.    S_AXI_AWPROT in 3   ignored.
//  S_AXI_AWVALID  in   1   /  S_AXI_AWREADY  out  1   write address handshake.
//  S_AXI_WDATA    in   32  write data.       S_AXI_WSTRB  in 4   byte enables.
//  S_AXI_WVALID   in   1   /  S_AXI_WREADY   out  1   write data handshake.
//  S_AXI_BRESP    out  2   always 2'b00 (OKAY).
//  S_AXI_BVALID   out  1   /  S_AXI_BREADY   in   1   write response handshake.
//  S_AXI_ARADDR   in   4   read address.     S_AXI_ARPROT in 3   ignored.
//  S_AXI_ARVALID  in   1   /  S_AXI_ARREADY  out  1   read address handshake.
//  S_AXI_RDATA    out  32  read data.        S_AXI_RRESP  out 2  always 2'b00.
//  S_AXI_RVALID   out  1   /  S_AXI_RREADY   in   1   read data handshake.
//  frame_start_i  in   1   one-cycle pulse from the VGA timing logic at vsync start.
//  shadow_o       out  4x32  frame-latched register copies for the pixel logic.
// BEHAVIOUR
//  Reset (async assert, sync release)
//   All registers, all shadows, RDATA, and every VALID/READY output go to 0.
//  Write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP
//   AWREADY=1 in W_IDLE and W_HAVE_W.  WREADY=1 in W_IDLE and W_HAVE_AW.
//   AW and W may arrive in either order or in the same cycle. Each is latched on its handshake.
//   When both are held, the commit happens on that same edge: the register is byte-merged using WSTRB.
//   After the commit, the FSM enters W_RESP with BVALID=1.
//   BVALID holds until BREADY; then return to W_IDLE. No new AW/W is accepted while in W_RESP.
//   Minimum write latency: AW+W in cycle N gives BVALID in cycle N+1.
//  Read FSM: R_IDLE, R_VALID
//   ARREADY=1 in R_IDLE only. On the handshake, RDATA is loaded with reg[ARADDR[3:2]] and RVALID=1 next cycle.
//   RDATA is stable while RVALID=1 and RREADY=0. The RVALID&RREADY handshake returns to R_IDLE.
//   Back-to-back reads give at most one read per 2 cycles.
//  Read/write collision
//   Read and write FSMs are independent. An AR accepted in the same cycle as a commit to the same register returns the pre-write value.
//  Shadows
//   On frame_start_i, shadow_o[i] <= reg[i] for all i.
//   If a commit coincides with frame_start_i, the shadow takes the pre-write value; the new value appears at the next frame.
//  Width rules
//   No address decode errors: every address maps to a register.
// STRUCTURE
//  Shared package vga_block_pkg
//   Constants REG_CTRL=0, REG_POS_X=1, REG_POS_Y=2, REG_COLOR=3.
//   Constant AXI_RESP_OKAY=2'b00.
//   typedef enum wr_state_t {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP}.
//   typedef enum rd_state_t {R_IDLE, R_VALID}.
//   typedef logic [31:0] reg_word_t.
//  No sub-module: the two FSMs and the register array stay in this module.
// TESTING
//  1. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four back -> 0x1..0x4, every BRESP/RRESP=OKAY.
//  2. AWVALID 3 cycles before WVALID, then repeat with WVALID 3 cycles before AWVALID -> single commit, BVALID exactly 1 cycle after the second handshake.
//  3. Reg 0x4=0x00000001; write 0xAABBCCDD with WSTRB=4'b0010 -> readback 0x0000CC01.
//  4. Hold BREADY=0 for 5 cycles -> BVALID stays 1, AWREADY=WREADY=0 throughout.
//     Hold RREADY=0 for 5 cycles -> RDATA stable.
//  5. Write 0x55 to 0x8 with no frame_start -> shadow_o[2] stays 0.
//     Pulse frame_start_i -> shadow_o[2]=0x55 next cycle.
//     Commit 0x66 in the same cycle as a frame_start pulse -> shadow_o[2]=0x55, then 0x66 after the next pulse.
//  6. Assert ARESETN=0 mid-write (in W_HAVE_AW) and mid-read (in R_VALID) -> all outputs 0 immediately, registers 0.
//     After release, a fresh write and readback succeed.

Source files
------------

// File: rtl/vga_block_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_block_pkg
// Brief  : Shared types and constants for the vga_block AXI4-Lite register file.
// Rev    : 1.0 - initial release
// ============================================================================
package vga_block_pkg;

    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_POS_X     = 2'd1;
    localparam logic [1:0] REG_POS_Y     = 2'd2;
    localparam logic [1:0] REG_COLOR     = 2'd3;
    localparam int         NUM_REGS      = int'(REG_COLOR) + 1;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef logic [31:0] reg_word_t;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_VALID} rd_state_t;

    // Overlay only the strobed bytes of new_w onto old_w.
    function automatic reg_word_t byte_merge(input reg_word_t old_w,
                                             input reg_word_t new_w,
                                             input logic [3:0] strb);
        reg_word_t m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_block_axil_regs.sv
`default_nettype none
// ============================================================================
// Module : vga_block_axil_regs
// Brief  : AXI4-Lite slave with 4 RW registers and frame-synchronous shadows.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_block_axil_regs
    import vga_block_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    input  logic                               frame_start_i,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] shadow_o
);

    wr_state_t  r_wstate;
    rd_state_t  r_rstate;
    reg_word_t  r_regs [NUM_REGS];
    logic [1:0] r_aw_idx;
    reg_word_t  r_wdata;
    logic [3:0] r_wstrb;

    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_ar_hs;
    logic       w_commit;
    logic [1:0] w_cm_idx;
    reg_word_t  w_cm_data;
    logic [3:0] w_cm_strb;
    logic       w_unused_ok;

    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_BRESP = AXI_RESP_OKAY;
    assign S_AXI_RRESP = AXI_RESP_OKAY;

    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Pick the commit source: whichever half arrives now comes from the bus, the other from the latch.
    always_comb begin
        w_commit  = 1'b0;
        w_cm_idx  = r_aw_idx;
        w_cm_data = r_wdata;
        w_cm_strb = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_commit  = w_aw_hs & w_w_hs;
                w_cm_idx  = S_AXI_AWADDR[3:2];
                w_cm_data = S_AXI_WDATA;
                w_cm_strb = S_AXI_WSTRB;
            end
            W_HAVE_AW: begin
                w_commit  = w_w_hs;
                w_cm_data = S_AXI_WDATA;
                w_cm_strb = S_AXI_WSTRB;
            end
            W_HAVE_W: begin
                w_commit  = w_aw_hs;
                w_cm_idx  = S_AXI_AWADDR[3:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i]   <= '0;
                shadow_o[i] <= '0;
            end
        end else begin
            // Shadows sample pre-commit values, so a coincident write shows up a frame later.
            if (frame_start_i) begin
                for (int i = 0; i < NUM_REGS; i++) shadow_o[i] <= r_regs[i];
            end
            if (w_commit) r_regs[w_cm_idx] <= byte_merge(r_regs[w_cm_idx], w_cm_data, w_cm_strb);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate      <= W_IDLE;
            r_aw_idx      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[3:2];
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_wstate      <= W_RESP;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
            end else begin
                case (r_wstate)
                    W_IDLE: begin
                        if (w_aw_hs) begin
                            r_wstate      <= W_HAVE_AW;
                            S_AXI_AWREADY <= 1'b0;
                            S_AXI_WREADY  <= 1'b1;
                        end else if (w_w_hs) begin
                            r_wstate      <= W_HAVE_W;
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b0;
                        end else begin
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b1;
                        end
                    end
                    W_RESP: begin
                        if (S_AXI_BREADY) begin
                            r_wstate      <= W_IDLE;
                            S_AXI_BVALID  <= 1'b0;
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate      <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate      <= R_VALID;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= r_regs[S_AXI_ARADDR[3:2]];
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_VALID: begin
                    if (S_AXI_RREADY) begin
                        r_rstate      <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_block_axil_regs.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_block_axil_regs
// Brief  : Directed self-checking bench for the vga_block AXI4-Lite registers.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vga_block_axil_regs;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, wvalid, bready, arvalid, rready, frame_start;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic [3:0][31:0]  shadow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_block_axil_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .frame_start_i (frame_start),
        .shadow_o      (shadow)
    );

    // Both halves offered together; each valid drops after its own handshake.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit aw_d = 0;
        bit w_d  = 0;
        int n    = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_d && w_d) && n < 20) begin
            if (awvalid && awready) aw_d = 1;
            if (wvalid && wready)   w_d  = 1;
            @(negedge clk); n++;
            if (aw_d) awvalid = 1'b0;
            if (w_d)  wvalid  = 1'b0;
        end
        while (!bvalid && n < 20) begin
            @(negedge clk); n++;
        end
        ok   = bvalid;
        resp = bresp;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin
            @(negedge clk); n++;
        end
        ok   = rvalid;
        d    = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        frame_start = 0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0 || shadow !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy/valid=%b rdata=%h shadow=%h, need all 0",
                     {awready, wready, bvalid, arready, rvalid}, rdata, shadow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_ready_up: got aw/w/ar ready=%b, need 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), 32'(i + 1), 4'hF, resp, ok);
            tests++;
            if (!ok || resp !== 2'b00) begin
                fails++;
                $display("FAIL basic_write%0d: got ok=%0d bresp=%b, need ok=1 bresp=00", i, ok, resp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), d, resp, ok);
            tests++;
            if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
                fails++;
                $display("FAIL basic_read%0d: got ok=%0d data=%h rresp=%b, need data=%h rresp=00",
                         i, ok, d, resp, 32'(i + 1));
            end
        end
    endtask

    task automatic test_aw_w_order();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        bit          early_b;
        for (int ord = 0; ord < 2; ord++) begin
            bready = 1'b1; awaddr = 4'hC; wdata = 32'h100 + 32'(ord); wstrb = 4'hF;
            if (ord == 0) awvalid = 1'b1; else wvalid = 1'b1;
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            tests++;
            if ({awready, wready} !== ((ord == 0) ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL order%0d_first_ready: got aw/w ready=%b", ord, {awready, wready});
            end
            early_b = bvalid;
            repeat (2) begin
                @(negedge clk);
                early_b |= bvalid;
            end
            if (ord == 0) wvalid = 1'b1; else awvalid = 1'b1;
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            tests++;
            if (early_b !== 1'b0 || bvalid !== 1'b1) begin
                fails++;
                $display("FAIL order%0d_bvalid: got early=%b bvalid=%b, need early=0 bvalid=1",
                         ord, early_b, bvalid);
            end
            @(negedge clk);
            do_read(4'hC, d, resp, ok);
            tests++;
            if (!ok || d !== 32'h100 + 32'(ord)) begin
                fails++;
                $display("FAIL order%0d_readback: got %h, need %h", ord, d, 32'h100 + 32'(ord));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        do_write(4'h4, 32'h1, 4'hF, resp, ok);
        do_write(4'h4, 32'hAABBCCDD, 4'b0010, resp, ok);
        do_read(4'h4, d, resp, ok);
        tests++;
        if (!ok || d !== 32'h0000CC01) begin
            fails++;
            $display("FAIL strobe_merge: got %h, need 0000cc01", d);
        end
    endtask

    task automatic test_backpressure();
        bit bad = 0;
        bready = 1'b0; awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (5) begin
            if ({bvalid, awready, wready} !== 3'b100) bad = 1;
            @(negedge clk);
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bready_hold: got b/aw/w=%b at end, need 100 for 5 cycles", {bvalid, awready, wready});
        end
        bready = 1'b1;
        @(negedge clk);
        tests++;
        if (bvalid !== 1'b0) begin
            fails++;
            $display("FAIL bready_release: got bvalid=%b, need 0", bvalid);
        end
        bad = 0;
        rready = 1'b0; araddr = 4'hC; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        repeat (5) begin
            if (rvalid !== 1'b1 || rdata !== 32'h101) bad = 1;
            @(negedge clk);
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL rready_hold: got rvalid=%b rdata=%h, need 1 / 00000101 for 5 cycles", rvalid, rdata);
        end
        rready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_collision();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h101 || bvalid !== 1'b1) begin
            fails++;
            $display("FAIL collision_old: got rvalid=%b rdata=%h bvalid=%b, need 1 00000101 1", rvalid, rdata, bvalid);
        end
        rready = 1'b1;
        @(negedge clk);
        do_read(4'hC, d, resp, ok);
        tests++;
        if (!ok || d !== 32'h77) begin
            fails++;
            $display("FAIL collision_new: got %h, need 00000077", d);
        end
    endtask

    task automatic test_shadow();
        logic [1:0] resp;
        bit         ok;
        do_write(4'h8, 32'h55, 4'hF, resp, ok);
        tests++;
        if (shadow[2] !== 32'h0) begin
            fails++;
            $display("FAIL shadow_no_frame: got %h, need 0", shadow[2]);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        tests++;
        if (shadow[2] !== 32'h55 || shadow[3] !== 32'h77 || shadow[1] !== 32'h0000CC01) begin
            fails++;
            $display("FAIL shadow_frame1: got s1=%h s2=%h s3=%h, need 0000cc01 00000055 00000077",
                     shadow[1], shadow[2], shadow[3]);
        end
        awaddr = 4'h8; wdata = 32'h66; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
        tests++;
        if (shadow[2] !== 32'h55) begin
            fails++;
            $display("FAIL shadow_coincident: got %h, need 00000055", shadow[2]);
        end
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        tests++;
        if (shadow[2] !== 32'h66) begin
            fails++;
            $display("FAIL shadow_frame2: got %h, need 00000066", shadow[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        bready = 1'b1; rready = 1'b0;
        awaddr = 4'h4; awvalid = 1'b1; araddr = 4'h4; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        tests++;
        if ({awready, wready, rvalid} !== 3'b011) begin
            fails++;
            $display("FAIL mid_state: got aw/w ready,rvalid=%b, need 011", {awready, wready, rvalid});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0 || shadow !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got rdy/valid=%b rdata=%h shadow=%h, need all 0",
                     {awready, wready, bvalid, arready, rvalid}, rdata, shadow);
        end
        @(negedge clk);
        rst_n = 1'b1; rready = 1'b1;
        @(negedge clk);
        do_read(4'h4, d, resp, ok);
        tests++;
        if (!ok || d !== 32'h0) begin
            fails++;
            $display("FAIL mid_reg_cleared: got %h, need 0", d);
        end
        do_write(4'h8, 32'hCAFE, 4'hF, resp, ok);
        do_read(4'h8, d, resp, ok);
        tests++;
        if (!ok || d !== 32'hCAFE) begin
            fails++;
            $display("FAIL mid_fresh_rw: got %h, need 0000cafe", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_w_order();
        test_strobe();
        test_backpressure();
        test_collision();
        test_shadow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
